// File: rtl/map_rom_arbiter.sv
// map_rom_arbiter: shares the single-port map tile ROM between the pixel renderer
// and physics collision queries. The renderer owns the port by default; an accepted
// physics query steals exactly one address cycle inside a horizontal/vertical blanking
// window and returns its tile on a valid pulse.
//
// Ports:
//   pixel_clk_in   - pixel clock, rising edge
//   rst_n_in       - asynchronous reset, active low
//   hcount_in      - current pixel column
//   vcount_in      - current pixel row
//   phys_req_in    - physics query request, held until accepted
//   phys_x_in      - query x in pixels
//   phys_y_in      - query y in pixels
//   phys_ready_out - query can be accepted this cycle
//   phys_valid_out - one-cycle pulse, phys_tile_out valid
//   phys_tile_out  - tile value of the last completed query
//   rom_addr_out   - map ROM address (render address except during the steal cycle)
//   rom_data_in    - map ROM read data, LATENCY cycles after the address
module map_rom_arbiter #(
   parameter int unsigned WIDTH      = 160,
   parameter int unsigned HEIGHT     = 90,
   parameter int unsigned TILE_SHIFT = 3,
   parameter int unsigned H_ACTIVE   = 1280,
   parameter int unsigned H_TOTAL    = 1650,
   parameter int unsigned V_ACTIVE   = 720,
   parameter int unsigned V_TOTAL    = 750,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned GUARD      = 4
) (
   input  logic                            pixel_clk_in,
   input  logic                            rst_n_in,
   input  logic [10:0]                     hcount_in,
   input  logic [9:0]                      vcount_in,
   input  logic                            phys_req_in,
   input  logic [10:0]                     phys_x_in,
   input  logic [9:0]                      phys_y_in,
   output logic                            phys_ready_out,
   output logic                            phys_valid_out,
   output logic [3:0]                      phys_tile_out,
   output logic [$clog2(WIDTH*HEIGHT)-1:0] rom_addr_out,
   input  logic [3:0]                      rom_data_in
);

   localparam int unsigned ADDR_W  = $clog2(WIDTH * HEIGHT);
   localparam int unsigned CNT_W   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned X_LIMIT = WIDTH << TILE_SHIFT;
   localparam int unsigned Y_LIMIT = HEIGHT << TILE_SHIFT;
   localparam int unsigned WIN_END = H_TOTAL - GUARD;

   // The steal cycle must land before line end, so the guard has to cover ROM latency.
   if (LATENCY < 1 || GUARD < LATENCY + 1 || H_TOTAL <= H_ACTIVE || V_TOTAL <= V_ACTIVE)
   begin : g_bad_params
      $error("map_rom_arbiter: inconsistent timing parameters");
   end

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [10:0]        x_q, x_d;
   logic [9:0]         y_q, y_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         tile_q, tile_d;
   logic               valid_q, valid_d;
   logic               started_q;

   logic               win;
   logic               ready_c;
   logic               accept_c;
   logic               oob_c;
   logic [ADDR_W-1:0]  render_addr;
   logic [ADDR_W-1:0]  phys_addr;

   // Tile addresses: constant multiply by map width only.
   assign render_addr = ADDR_W'(hcount_in >> TILE_SHIFT)
                      + ADDR_W'(vcount_in >> TILE_SHIFT) * ADDR_W'(WIDTH);
   assign phys_addr   = ADDR_W'(x_q >> TILE_SHIFT)
                      + ADDR_W'(y_q >> TILE_SHIFT) * ADDR_W'(WIDTH);

   // Blanking window, minus the guard cycles at the end of each line.
   assign win = ((hcount_in >= 11'(H_ACTIVE)) && (hcount_in < 11'(WIN_END)))
              || (vcount_in >= 10'(V_ACTIVE));

   assign oob_c    = (32'(x_q) >= X_LIMIT) || (32'(y_q) >= Y_LIMIT);
   // started_q holds ready low until the first clock after reset.
   assign ready_c  = (state_q == S_IDLE) && win && started_q;
   assign accept_c = ready_c && phys_req_in;

   // State and registered outputs.
   always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q   <= S_IDLE;
         x_q       <= '0;
         y_q       <= '0;
         cnt_q     <= '0;
         tile_q    <= '0;
         valid_q   <= 1'b0;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         x_q       <= x_d;
         y_q       <= y_d;
         cnt_q     <= cnt_d;
         tile_q    <= tile_d;
         valid_q   <= valid_d;
         started_q <= 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (accept_c) state_d = S_ISSUE;
         S_ISSUE: state_d = oob_c ? S_RESP : S_WAIT;
         S_WAIT:  if (cnt_q == '0) state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output / datapath logic.
   always_comb begin
      x_d            = x_q;
      y_d            = y_q;
      cnt_d          = cnt_q;
      tile_d         = tile_q;
      valid_d        = 1'b0;
      phys_ready_out = 1'b0;
      rom_addr_out   = render_addr;
      unique case (state_q)
         S_IDLE: begin
            phys_ready_out = ready_c;
            if (accept_c) begin
               x_d = phys_x_in;
               y_d = phys_y_in;
            end
         end
         S_ISSUE: begin
            // Out-of-bounds queries never touch the ROM port.
            if (oob_c) begin
               tile_d  = 4'hF;
               valid_d = 1'b1;
            end else begin
               rom_addr_out = phys_addr;
               cnt_d        = CNT_W'(LATENCY - 1);
            end
         end
         S_WAIT: begin
            if (cnt_q == '0) begin
               tile_d  = rom_data_in;
               valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_RESP: begin
         end
         default: begin
         end
      endcase
   end

   assign phys_valid_out = valid_q;
   assign phys_tile_out  = tile_q;

endmodule

// File: tb/tb_map_rom_arbiter.sv
// tb_map_rom_arbiter: randomized and directed checks of map_rom_arbiter against a
// behavioural model of the raster window, tile addressing and query latency.
module tb_map_rom_arbiter;

   localparam int MAP_W    = 160;
   localparam int MAP_H    = 90;
   localparam int TILE_PX  = 8;
   localparam int H_ACTIVE = 1280;
   localparam int H_TOTAL  = 1650;
   localparam int V_ACTIVE = 720;
   localparam int V_TOTAL  = 750;
   localparam int LATENCY  = 2;
   localparam int GUARD    = 4;
   localparam int ADDR_W   = 14;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [10:0]       hcount;
   logic [9:0]        vcount;
   logic              phys_req;
   logic [10:0]       phys_x;
   logic [9:0]        phys_y;
   logic              phys_ready;
   logic              phys_valid;
   logic [3:0]        phys_tile;
   logic [ADDR_W-1:0] rom_addr;
   logic [3:0]        rom_data;

   logic [3:0]        mem [0:16383];
   logic [3:0]        rom_s1, rom_s2;

   int total = 0;
   int bad   = 0;
   int cyc_n = 0;

   always #5 clk = ~clk;

   map_rom_arbiter dut (
      .pixel_clk_in   (clk),
      .rst_n_in       (rst_n),
      .hcount_in      (hcount),
      .vcount_in      (vcount),
      .phys_req_in    (phys_req),
      .phys_x_in      (phys_x),
      .phys_y_in      (phys_y),
      .phys_ready_out (phys_ready),
      .phys_valid_out (phys_valid),
      .phys_tile_out  (phys_tile),
      .rom_addr_out   (rom_addr),
      .rom_data_in    (rom_data)
   );

   // Registered-output block RAM with two cycles of read latency.
   always_ff @(posedge clk) begin
      rom_s1 <= mem[rom_addr];
      rom_s2 <= rom_s1;
   end
   assign rom_data = rom_s2;

   function automatic bit win_f(input int h, input int v);
      return (h >= H_ACTIVE && h < H_TOTAL - GUARD) || (v >= V_ACTIVE);
   endfunction

   function automatic int tile_index_f(input int px, input int py);
      return (px / TILE_PX) + (py / TILE_PX) * MAP_W;
   endfunction

   function automatic bit oob_f(input int px, input int py);
      return (px >= MAP_W * TILE_PX) || (py >= MAP_H * TILE_PX);
   endfunction

   // Move the raster to (h,v) for the next cycle; returns at the sampling point.
   task automatic jump(input int h, input int v);
      @(posedge clk);
      #1;
      hcount = 11'(h);
      vcount = 10'(v);
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic tick();
      int h;
      int v;
      h = int'(hcount) + 1;
      v = int'(vcount);
      if (h >= H_TOTAL) begin
         h = 0;
         v = v + 1;
         if (v >= V_TOTAL) v = 0;
      end
      jump(h, v);
   endtask

   // Raise a query, wait for the window, then follow it to its valid pulse.
   task automatic do_query(input int x, input int y, input int bound, output int acc);
      int         waited;
      int         lat;
      int         exp_addr;
      int         h;
      int         v;
      bit         oob;
      logic [3:0] exp_tile;
      acc      = -1;
      phys_x   = 11'(x);
      phys_y   = 10'(y);
      phys_req = 1'b1;
      waited   = 0;
      forever begin
         h = int'(hcount);
         v = int'(vcount);
         total++;
         if (phys_ready !== win_f(h, v)) begin
            bad++;
            $display("FAIL ready_window: got %0b expected %0b at h=%0d v=%0d", phys_ready, win_f(h, v), h, v);
         end
         total++;
         if (rom_addr !== ADDR_W'(tile_index_f(h, v))) begin
            bad++;
            $display("FAIL render_addr_wait: got %0d expected %0d at h=%0d v=%0d", rom_addr, tile_index_f(h, v), h, v);
         end
         total++;
         if (phys_valid !== 1'b0) begin
            bad++;
            $display("FAIL valid_idle: got %0b expected 0 at h=%0d v=%0d", phys_valid, h, v);
         end
         if (win_f(h, v)) break;
         if (waited >= bound) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: waited %0d cycles expected accept within %0d", waited, bound);
            phys_req = 1'b0;
            return;
         end
         tick();
         waited++;
      end
      acc      = cyc_n;
      oob      = oob_f(x, y);
      exp_addr = oob ? 0 : tile_index_f(x, y);
      lat      = oob ? 2 : LATENCY + 2;
      exp_tile = oob ? 4'hF : mem[exp_addr];
      for (int k = 1; k <= lat; k++) begin
         tick();
         if (k == 1) phys_req = 1'b0;
         h = int'(hcount);
         v = int'(vcount);
         total++;
         if (phys_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_busy: got %0b expected 0 at +%0d", phys_ready, k);
         end
         total++;
         if (phys_valid !== (k == lat)) begin
            bad++;
            $display("FAIL valid_timing: got %0b expected %0b at +%0d", phys_valid, (k == lat), k);
         end
         total++;
         if (k == 1 && !oob) begin
            if (rom_addr !== ADDR_W'(exp_addr)) begin
               bad++;
               $display("FAIL steal_addr: got %0d expected %0d", rom_addr, exp_addr);
            end
         end else if (rom_addr !== ADDR_W'(tile_index_f(h, v))) begin
            bad++;
            $display("FAIL render_addr_busy: got %0d expected %0d at +%0d", rom_addr, tile_index_f(h, v), k);
         end
         if (k == lat) begin
            total++;
            if (phys_tile !== exp_tile) begin
               bad++;
               $display("FAIL tile_value: got %0h expected %0h x=%0d y=%0d", phys_tile, exp_tile, x, y);
            end
         end
      end
      tick();
      total++;
      if (phys_valid !== 1'b0 || phys_tile !== exp_tile) begin
         bad++;
         $display("FAIL after_resp: valid=%0b tile=%0h expected valid=0 tile=%0h", phys_valid, phys_tile, exp_tile);
      end
   endtask

   task automatic test_reset();
      rst_n    = 1'b0;
      hcount   = 11'd100;
      vcount   = 10'd50;
      phys_req = 1'b0;
      phys_x   = '0;
      phys_y   = '0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         total++;
         if (rom_addr !== 14'd972 || phys_ready !== 1'b0 || phys_valid !== 1'b0 || phys_tile !== 4'h0) begin
            bad++;
            $display("FAIL reset_state: addr=%0d ready=%0b valid=%0b tile=%0h expected 972/0/0/0",
                     rom_addr, phys_ready, phys_valid, phys_tile);
         end
      end
      // Inside the window but still in reset: ready must stay low.
      hcount   = 11'd1300;
      phys_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         total++;
         if (phys_ready !== 1'b0 || phys_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: ready=%0b valid=%0b expected 0/0", phys_ready, phys_valid);
         end
      end
      phys_req = 1'b0;
      rst_n    = 1'b1;
      #1;
      total++;
      if (phys_ready !== 1'b0) begin
         bad++;
         $display("FAIL ready_before_first_clock: got %0b expected 0", phys_ready);
      end
      tick();
      total++;
      if (phys_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_first_clock: got %0b expected 1", phys_ready);
      end
   endtask

   task automatic test_single();
      int acc;
      jump(1300, 10);
      do_query(16, 24, 5, acc);
   endtask

   task automatic test_hold_from_active();
      int start;
      int acc;
      jump(200, 10);
      start = cyc_n;
      do_query(40, 40, 2000, acc);
      total++;
      if (acc - start != H_ACTIVE - 200) begin
         bad++;
         $display("FAIL hold_accept_cycle: got %0d expected %0d", acc - start, H_ACTIVE - 200);
      end
   endtask

   task automatic test_window_edge();
      int start;
      int acc;
      jump(H_TOTAL - GUARD - 1, 20);
      start = cyc_n;
      do_query(8, 8, 5, acc);
      total++;
      if (acc != start) begin
         bad++;
         $display("FAIL edge_1645_accept: got %0d expected %0d", acc - start, 0);
      end
      jump(H_TOTAL - GUARD, 21);
      start = cyc_n;
      do_query(100, 300, 2000, acc);
      total++;
      if (acc - start != GUARD + H_ACTIVE) begin
         bad++;
         $display("FAIL edge_1646_accept: got %0d expected %0d", acc - start, GUARD + H_ACTIVE);
      end
   endtask

   task automatic test_oob();
      int acc;
      jump(1300, 5);
      do_query(1280, 0, 5, acc);
      do_query(0, 720, 5, acc);
      do_query(1279, 719, 5, acc);
   endtask

   task automatic test_back_to_back();
      int acc;
      int prev;
      bit prev_oob;
      int x;
      int y;
      jump(0, 730);
      prev     = -1;
      prev_oob = 1'b0;
      for (int i = 0; i < 6; i++) begin
         x = ($urandom_range(0, 3) == 0) ? 1300 : int'($urandom_range(0, 1279));
         y = int'($urandom_range(0, 719));
         do_query(x, y, 10, acc);
         if (prev >= 0) begin
            total++;
            if (acc - prev != (prev_oob ? 3 : LATENCY + 3)) begin
               bad++;
               $display("FAIL b2b_spacing: got %0d expected %0d", acc - prev, prev_oob ? 3 : LATENCY + 3);
            end
         end
         prev     = acc;
         prev_oob = oob_f(x, y);
      end
   endtask

   task automatic test_reset_mid_query();
      int acc;
      jump(1300, 30);
      phys_x   = 11'd80;
      phys_y   = 10'd96;
      phys_req = 1'b1;
      tick();
      phys_req = 1'b0;
      tick();
      #1;
      rst_n = 1'b0;
      #1;
      total++;
      if (phys_valid !== 1'b0 || phys_tile !== 4'h0 || phys_ready !== 1'b0) begin
         bad++;
         $display("FAIL reset_in_wait: valid=%0b tile=%0h ready=%0b expected 0/0/0", phys_valid, phys_tile, phys_ready);
      end
      tick();
      rst_n = 1'b1;
      #1;
      total++;
      if (phys_ready !== 1'b0 || phys_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: ready=%0b valid=%0b expected 0/0", phys_ready, phys_valid);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         total++;
         if (phys_valid !== 1'b0 || phys_tile !== 4'h0) begin
            bad++;
            $display("FAIL aborted_query: valid=%0b tile=%0h expected 0/0", phys_valid, phys_tile);
         end
      end
      do_query(80, 96, 5, acc);
   endtask

   task automatic test_random();
      int acc;
      for (int i = 0; i < 20; i++) begin
         jump(int'($urandom_range(0, H_TOTAL - 1)), int'($urandom_range(0, V_TOTAL - 1)));
         do_query(int'($urandom_range(0, 1350)), int'($urandom_range(0, 760)), 2000, acc);
      end
   endtask

   initial begin
      // Tiles never 0 or F, so reset and out-of-bounds values stand out.
      for (int i = 0; i < 16384; i++) mem[i] = 4'($urandom_range(1, 14));
      test_reset();
      test_single();
      test_hold_from_active();
      test_window_edge();
      test_oob();
      test_back_to_back();
      test_reset_mid_query();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
